// File: rtl/clfsr_sync_checker_if.sv
// Stream and status signals between a bit source (master) and the
// LFSR sync checker (slave).
interface clfsr_sync_checker_if;
  logic        in_bit;
  logic        in_valid;
  logic        clr;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  modport master (
    output in_bit, in_valid, clr,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  in_bit, in_valid, clr,
    output locked, err_pulse, err_count
  );
endinterface

// File: rtl/clfsr_sync_checker.sv
// Self-synchronising receive checker for the LFSR keystream: hunt, verify, flywheel lock.
// Optional saturating mismatch counter is built when CLFSR_CHK_ERRCNT_EN is defined.
module clfsr_sync_checker #(
  parameter int              WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS    = 16'hB400,
  parameter int              LOCK_CNT = 32,
  parameter int              WINDOW   = 64,
  parameter int              ERR_MAX  = 4
) (
  input logic                 clk,
  input logic                 rst,
  clfsr_sync_checker_if.slave bus
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(ERR_MAX + 1);

  localparam logic [FW-1:0] FILL_FULL  = FW'(WIDTH);
  localparam logic [FW-1:0] FILL_LAST  = FW'(WIDTH - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(ERR_MAX - 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sr_reg;
  logic [FW-1:0]    fill_reg;
  logic [MW-1:0]    match_cnt_reg;
  logic [WW-1:0]    win_cnt_reg;
  logic [EW-1:0]    err_cnt_win_reg;
  logic             locked_reg;
  logic             err_pulse_reg;

  logic [WIDTH-1:0] tap_terms;
  logic             pred;
  logic             mismatch;
  logic [WIDTH-1:0] sr_in;
  logic [WIDTH-1:0] sr_fly;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
    assign tap_terms[gi] = sr_reg[gi] & TAPS[gi];
  end

  assign pred     = ^tap_terms;
  assign mismatch = bus.in_bit ^ pred;
  assign sr_in    = {sr_reg[WIDTH-2:0], bus.in_bit};
  // While locked the register regenerates itself, so line errors never enter it.
  assign sr_fly   = {sr_reg[WIDTH-2:0], pred};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= HUNT;
      sr_reg          <= '0;
      fill_reg        <= '0;
      match_cnt_reg   <= '0;
      win_cnt_reg     <= '0;
      err_cnt_win_reg <= '0;
      locked_reg      <= 1'b0;
      err_pulse_reg   <= 1'b0;
    end else begin
      err_pulse_reg <= 1'b0;
      if (bus.in_valid) begin
        unique case (state_reg)
          HUNT: begin
            sr_reg <= sr_in;
            if (fill_reg >= FILL_LAST) begin
              fill_reg <= FILL_FULL;
              if (|sr_in) begin
                state_reg     <= VERIFY;
                match_cnt_reg <= '0;
              end
            end else begin
              fill_reg <= fill_reg + FW'(1);
            end
          end
          VERIFY: begin
            sr_reg <= sr_in;
            if (mismatch) begin
              state_reg <= HUNT;
              fill_reg  <= FW'(1);
            end else if (match_cnt_reg == MATCH_LAST) begin
              state_reg       <= LOCKED;
              locked_reg      <= 1'b1;
              win_cnt_reg     <= '0;
              err_cnt_win_reg <= '0;
            end else begin
              match_cnt_reg <= match_cnt_reg + MW'(1);
            end
          end
          LOCKED: begin
            sr_reg        <= sr_fly;
            err_pulse_reg <= mismatch;
            // Loss test comes first so a last-of-window error still counts in its window.
            if (mismatch && (err_cnt_win_reg == ERR_LAST)) begin
              state_reg       <= HUNT;
              fill_reg        <= '0;
              locked_reg      <= 1'b0;
              win_cnt_reg     <= '0;
              err_cnt_win_reg <= '0;
            end else if (win_cnt_reg == WIN_LAST) begin
              win_cnt_reg     <= '0;
              err_cnt_win_reg <= '0;
            end else begin
              win_cnt_reg <= win_cnt_reg + WW'(1);
              if (mismatch) err_cnt_win_reg <= err_cnt_win_reg + EW'(1);
            end
          end
          default: begin
            state_reg  <= HUNT;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked    = locked_reg;
  assign bus.err_pulse = err_pulse_reg;

`ifdef CLFSR_CHK_ERRCNT_EN
  logic [15:0] err_count_reg;
  logic        count_err;

  assign count_err = bus.in_valid && (state_reg == LOCKED) && mismatch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count_reg <= '0;
    end else if (bus.clr) begin
      err_count_reg <= {15'd0, count_err};
    end else if (count_err && (err_count_reg != 16'hFFFF)) begin
      err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign bus.err_count = err_count_reg;
`else
  logic unused_clr;
  assign unused_clr    = bus.clr;
  assign bus.err_count = 16'd0;
`endif

endmodule

// File: tb/tb_clfsr_sync_checker.sv
// Bench for clfsr_sync_checker: scenario table, hand sequences for corner cases,
// and randomized streams compared cycle by cycle against a history-based model.
module tb_clfsr_sync_checker;
  localparam int          WIDTH    = 16;
  localparam logic [15:0] TAPS     = 16'hB400;
  localparam int          LOCK_CNT = 32;
  localparam int          WINDOW   = 64;
  localparam int          ERR_MAX  = 4;
  localparam int          M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;
`ifdef CLFSR_CHK_ERRCNT_EN
  localparam bit          ERRCNT_EN = 1'b1;
`else
  localparam bit          ERRCNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  clfsr_sync_checker_if bus ();

  clfsr_sync_checker #(
    .WIDTH(WIDTH), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .ERR_MAX(ERR_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic [15:0] taps_v = TAPS;
  logic [15:0] gen_sr = 16'hACE1;

  // Reference model: register contents kept as a bit history, newest first.
  int m_mode, m_fill, m_match, m_wpos, m_werr, m_errs;
  bit m_hist[$];
  bit m_locked, m_pulse;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pred();
    bit p = 1'b0;
    for (int i = 0; i < m_hist.size(); i++) if (taps_v[i]) p ^= m_hist[i];
    return p;
  endfunction

  function automatic bit m_any_one();
    bit a = 1'b0;
    foreach (m_hist[i]) a |= m_hist[i];
    return a;
  endfunction

  task automatic m_push(input bit x);
    m_hist.push_front(x);
    if (m_hist.size() > WIDTH) void'(m_hist.pop_back());
  endtask

  task automatic model_reset();
    m_mode = M_HUNT; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0; m_errs = 0;
    m_hist.delete();
    m_locked = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit b, input bit v, input bit c);
    bit p;
    p = m_pred();
    m_pulse = 1'b0;
    if (c) m_errs = 0;
    if (v) begin
      case (m_mode)
        M_HUNT: begin
          m_push(b);
          m_fill = (m_fill + 1 > WIDTH) ? WIDTH : m_fill + 1;
          if (m_fill == WIDTH && m_any_one()) begin
            m_mode = M_VERIFY; m_match = 0;
          end
        end
        M_VERIFY: begin
          m_push(b);
          if (b != p) begin
            m_mode = M_HUNT; m_fill = 1;
          end else begin
            m_match++;
            if (m_match == LOCK_CNT) begin
              m_mode = M_LOCKED; m_locked = 1'b1; m_wpos = 0; m_werr = 0;
            end
          end
        end
        default: begin
          m_push(p);
          if (b != p) begin
            m_pulse = 1'b1;
            if (m_errs < 65535) m_errs++;
            m_werr++;
          end
          if (m_werr == ERR_MAX) begin
            m_mode = M_HUNT; m_fill = 0; m_locked = 1'b0; m_wpos = 0; m_werr = 0;
          end else begin
            m_wpos++;
            if (m_wpos == WINDOW) begin m_wpos = 0; m_werr = 0; end
          end
        end
      endcase
    end
  endtask

  function automatic int exp_cnt();
    return ERRCNT_EN ? m_errs : 0;
  endfunction

  task automatic gen_bit(output bit b);
    b = ^(gen_sr & taps_v);
    gen_sr = {gen_sr[14:0], b};
  endtask

  task automatic step(input bit b, input bit v, input bit c);
    @(negedge clk);
    bus.in_bit = b; bus.in_valid = v; bus.clr = c;
    @(posedge clk);
    model_step(b, v, c);
    #1;
    check("locked", int'(bus.locked), int'(m_locked));
    check("err_pulse", int'(bus.err_pulse), int'(m_pulse));
    check("err_count", int'(bus.err_count), exp_cnt());
    if (bus.err_pulse) pulses++;
  endtask

  task automatic feed_clean(input int n);
    bit b;
    repeat (n) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_locked", int'(bus.locked), 0);
    check("rst_err_pulse", int'(bus.err_pulse), 0);
    check("rst_err_count", int'(bus.err_count), 0);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0; bus.clr = 1'b0; bus.in_bit = 1'b0;
    rst = 1'b1;
  endtask

  function automatic logic [255:0] mk(input int p0, input int p1, input int p2,
                                      input int p3, input int p4, input int p5);
    logic [255:0] m = '0;
    int p[6] = '{p0, p1, p2, p3, p4, p5};
    foreach (p[i]) if (p[i] >= 0) m[p[i]] = 1'b1;
    return m;
  endfunction

  // Error positions are counted from the first valid bit after lock (window start).
  typedef struct {
    logic [15:0]  seed;
    logic [255:0] errs;
    int           post;
    bit           exp_locked;
    int           exp_pulses;
  } rec_t;

  rec_t tbl[7];

  initial begin
    bit b;
    bit seen;
    int flip_div;

    bus.in_bit = 1'b0; bus.in_valid = 1'b0; bus.clr = 1'b0;

    tbl[0] = '{16'hACE1, mk(-1, -1, -1, -1, -1, -1), 100, 1'b1, 0};
    tbl[1] = '{16'hACE1, mk(10, -1, -1, -1, -1, -1), 101, 1'b1, 1};
    tbl[2] = '{16'h1234, mk(5, 20, 40, 63, -1, -1), 100, 1'b0, 4};
    tbl[3] = '{16'h1234, mk(5, 20, 40, 63, -1, -1), 130, 1'b1, 4};
    tbl[4] = '{16'hBEEF, mk(10, 30, 63, 64, 80, 100), 140, 1'b1, 6};
    tbl[5] = '{16'h0001, mk(0, 1, 2, 3, 4, -1), 200, 1'b1, 4};
    tbl[6] = '{16'h5A5A, mk(60, 61, 62, 64, -1, -1), 100, 1'b1, 4};

    #2;
    do_reset();

    for (int r = 0; r < 7; r++) begin
      do_reset();
      gen_sr = tbl[r].seed;
      feed_clean(WIDTH + LOCK_CNT - 1);
      check("acq_early", int'(bus.locked), 0);
      feed_clean(1);
      check("acq_lock", int'(bus.locked), 1);
      pulses = 0;
      for (int k = 0; k < tbl[r].post; k++) begin
        gen_bit(b);
        step(b ^ tbl[r].errs[k], 1'b1, 1'b0);
      end
      check("tbl_locked", int'(bus.locked), int'(tbl[r].exp_locked));
      check("tbl_pulses", pulses, tbl[r].exp_pulses);
      check("tbl_err_count", int'(bus.err_count), ERRCNT_EN ? tbl[r].exp_pulses : 0);
    end

    // All-zero input must never pass the hunt.
    do_reset();
    seen = 1'b0;
    repeat (200) begin
      step(1'b0, 1'b1, 1'b0);
      if (bus.locked) seen = 1'b1;
    end
    check("zero_lockup", int'(seen), 0);

    // Idle gaps during acquisition: lock still lands on the 48th valid bit.
    do_reset();
    gen_sr = 16'hACE1;
    for (int v = 1; v <= WIDTH + LOCK_CNT; v++) begin
      if (v == 20 || $urandom_range(0, 9) == 0)
        repeat (10) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      gen_bit(b);
      step(b, 1'b1, 1'b0);
      if (v == WIDTH + LOCK_CNT - 1) check("gap_early", int'(bus.locked), 0);
    end
    check("gap_lock", int'(bus.locked), 1);

    // Five errors spread over two windows, then clear, then clear with a coincident error.
    for (int k = 0; k < 70; k++) begin
      gen_bit(b);
      step(b ^ (k == 0 || k == 1 || k == 2 || k == 64 || k == 65), 1'b1, 1'b0);
    end
    check("clr_pre", int'(bus.err_count), ERRCNT_EN ? 5 : 0);
    gen_bit(b);
    step(b, 1'b1, 1'b1);
    check("clr_zero", int'(bus.err_count), 0);
    gen_bit(b);
    step(~b, 1'b1, 1'b1);
    check("clr_with_err", int'(bus.err_count), ERRCNT_EN ? 1 : 0);
    check("clr_with_err_pulse", int'(bus.err_pulse), 1);
    check("clr_still_locked", int'(bus.locked), 1);

    // Asynchronous reset while locked with a pulse showing.
    do_reset();

    // Randomized streams with gaps, flips and clears against the model.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      gen_sr = 16'($urandom_range(1, 65535));
      flip_div = (r == 0) ? 100 : (r == 1) ? 30 : (r == 2) ? 12 : 6;
      repeat (600) begin
        if ($urandom_range(0, 7) == 0) begin
          step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 49) == 0));
        end else begin
          gen_bit(b);
          step(b ^ 1'($urandom_range(0, flip_div - 1) == 0), 1'b1,
               1'($urandom_range(0, 49) == 0));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
